// File: rtl/input_p4_interface.sv
`default_nettype none
// ============================================================================
// input_p4_interface : ingress demux steering whole packets to one of five
//                      virtual P4 switches by 802.1Q VID; unmapped are dropped
// Revision 1.0
// ============================================================================
module input_p4_interface #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 304,
    parameter int C_S_AXIS_TUSER_WIDTH = 304,
    parameter int NUM_SWITCHES         = 5,
    parameter int VID_BASE             = 1
) (
    input  logic                              axis_aclk,
    input  logic                              axis_resetn,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_0_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_0_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_0_tuser,
    output logic                              m_axis_0_tvalid,
    input  logic                              m_axis_0_tready,
    output logic                              m_axis_0_tlast,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_1_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_1_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_1_tuser,
    output logic                              m_axis_1_tvalid,
    input  logic                              m_axis_1_tready,
    output logic                              m_axis_1_tlast,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_2_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_2_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_2_tuser,
    output logic                              m_axis_2_tvalid,
    input  logic                              m_axis_2_tready,
    output logic                              m_axis_2_tlast,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_3_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_3_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_3_tuser,
    output logic                              m_axis_3_tvalid,
    input  logic                              m_axis_3_tready,
    output logic                              m_axis_3_tlast,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_4_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_4_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_4_tuser,
    output logic                              m_axis_4_tvalid,
    input  logic                              m_axis_4_tready,
    output logic                              m_axis_4_tlast,

    output logic                              pkt_fwd,
    output logic                              pkt_drop,
    output logic [31:0]                       drop_count
);

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } state_t;

    localparam logic [11:0] C_VID_BASE = 12'(VID_BASE);
    localparam logic [11:0] C_NUM_SW   = 12'(NUM_SWITCHES);

    state_t      state_q;
    logic [2:0]  sel_q;
    logic        pkt_fwd_q;
    logic        pkt_drop_q;
    logic [31:0] drop_count_q;

    logic        w_tagged;
    logic        w_match;
    logic [11:0] w_vid;
    logic [11:0] w_idx;
    logic [2:0]  w_route;
    logic        w_route_rdy;
    logic        w_route_en;
    logic        w_s_rdy;
    logic        w_hs;
    logic [4:0]  w_m_vld;

    // Header bytes 12..15 of the first beat: TPID 0x8100 then TCI (PCP/DEI ignored)
    assign w_tagged = (s_axis_tdata[103:96] == 8'h81) && (s_axis_tdata[111:104] == 8'h00);
    assign w_vid    = {s_axis_tdata[115:112], s_axis_tdata[127:120]};
    assign w_idx    = w_vid - C_VID_BASE;
    assign w_match  = w_tagged && (w_vid >= C_VID_BASE) && (w_idx < C_NUM_SW);

    assign w_route  = (state_q == HDR) ? w_idx[2:0] : sel_q;

    always_comb begin
        case (w_route)
            3'd0:    w_route_rdy = m_axis_0_tready;
            3'd1:    w_route_rdy = m_axis_1_tready;
            3'd2:    w_route_rdy = m_axis_2_tready;
            3'd3:    w_route_rdy = m_axis_3_tready;
            3'd4:    w_route_rdy = m_axis_4_tready;
            default: w_route_rdy = 1'b0;
        endcase
    end

    always_comb begin
        w_route_en = 1'b0;
        w_s_rdy    = 1'b0;
        case (state_q)
            HDR: begin
                if (s_axis_tvalid) begin
                    w_route_en = w_match;
                    w_s_rdy    = w_match ? w_route_rdy : 1'b1;
                end
            end
            FWD: begin
                w_route_en = s_axis_tvalid;
                w_s_rdy    = w_route_rdy;
            end
            DROP:    w_s_rdy = 1'b1;
            default: w_s_rdy = 1'b0;
        endcase
        if (!axis_resetn) begin
            w_route_en = 1'b0;
            w_s_rdy    = 1'b0;
        end
        for (int k = 0; k < 5; k++) begin
            w_m_vld[k] = w_route_en && (w_route == k[2:0]);
        end
    end

    assign w_hs = s_axis_tvalid && w_s_rdy;

    always_ff @(posedge axis_aclk) begin
        if (!axis_resetn) begin
            state_q      <= HDR;
            sel_q        <= 3'd0;
            pkt_fwd_q    <= 1'b0;
            pkt_drop_q   <= 1'b0;
            drop_count_q <= 32'd0;
        end else begin
            pkt_fwd_q  <= 1'b0;
            pkt_drop_q <= 1'b0;
            case (state_q)
                HDR: begin
                    if (w_hs) begin
                        if (w_match) begin
                            sel_q     <= w_idx[2:0];
                            pkt_fwd_q <= 1'b1;
                            if (!s_axis_tlast) state_q <= FWD;
                        end else begin
                            pkt_drop_q   <= 1'b1;
                            drop_count_q <= drop_count_q + 32'd1;
                            if (!s_axis_tlast) state_q <= DROP;
                        end
                    end
                end
                FWD, DROP: begin
                    if (w_hs && s_axis_tlast) state_q <= HDR;
                end
                default: state_q <= HDR;
            endcase
        end
    end

    assign s_axis_tready = w_s_rdy;
    assign pkt_fwd       = pkt_fwd_q;
    assign pkt_drop      = pkt_drop_q;
    assign drop_count    = drop_count_q;

    assign m_axis_0_tvalid = w_m_vld[0];
    assign m_axis_1_tvalid = w_m_vld[1];
    assign m_axis_2_tvalid = w_m_vld[2];
    assign m_axis_3_tvalid = w_m_vld[3];
    assign m_axis_4_tvalid = w_m_vld[4];

    assign m_axis_0_tdata = s_axis_tdata;
    assign m_axis_1_tdata = s_axis_tdata;
    assign m_axis_2_tdata = s_axis_tdata;
    assign m_axis_3_tdata = s_axis_tdata;
    assign m_axis_4_tdata = s_axis_tdata;
    assign m_axis_0_tkeep = s_axis_tkeep;
    assign m_axis_1_tkeep = s_axis_tkeep;
    assign m_axis_2_tkeep = s_axis_tkeep;
    assign m_axis_3_tkeep = s_axis_tkeep;
    assign m_axis_4_tkeep = s_axis_tkeep;
    assign m_axis_0_tuser = s_axis_tuser;
    assign m_axis_1_tuser = s_axis_tuser;
    assign m_axis_2_tuser = s_axis_tuser;
    assign m_axis_3_tuser = s_axis_tuser;
    assign m_axis_4_tuser = s_axis_tuser;
    assign m_axis_0_tlast = s_axis_tlast;
    assign m_axis_1_tlast = s_axis_tlast;
    assign m_axis_2_tlast = s_axis_tlast;
    assign m_axis_3_tlast = s_axis_tlast;
    assign m_axis_4_tlast = s_axis_tlast;

endmodule
`default_nettype wire

// File: tb/tb_input_p4_interface.sv
`default_nettype none
// ============================================================================
// tb_input_p4_interface : directed self-checking bench for input_p4_interface
// Revision 1.0
// ============================================================================
module tb_input_p4_interface;

    logic         clk;
    logic         rstn;
    logic [255:0] s_tdata;
    logic [31:0]  s_tkeep;
    logic [303:0] s_tuser;
    logic         s_tvalid;
    logic         s_tready;
    logic         s_tlast;
    logic [255:0] m_tdata [5];
    logic [31:0]  m_tkeep [5];
    logic [303:0] m_tuser [5];
    logic         m_tvalid [5];
    logic         m_tready [5];
    logic         m_tlast [5];
    logic         pkt_fwd;
    logic         pkt_drop;
    logic [31:0]  drop_count;
    logic [4:0]   vld;

    int tests = 0;
    int fails = 0;

    input_p4_interface dut (
        .axis_aclk(clk), .axis_resetn(rstn),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
        .m_axis_0_tdata(m_tdata[0]), .m_axis_0_tkeep(m_tkeep[0]), .m_axis_0_tuser(m_tuser[0]),
        .m_axis_0_tvalid(m_tvalid[0]), .m_axis_0_tready(m_tready[0]), .m_axis_0_tlast(m_tlast[0]),
        .m_axis_1_tdata(m_tdata[1]), .m_axis_1_tkeep(m_tkeep[1]), .m_axis_1_tuser(m_tuser[1]),
        .m_axis_1_tvalid(m_tvalid[1]), .m_axis_1_tready(m_tready[1]), .m_axis_1_tlast(m_tlast[1]),
        .m_axis_2_tdata(m_tdata[2]), .m_axis_2_tkeep(m_tkeep[2]), .m_axis_2_tuser(m_tuser[2]),
        .m_axis_2_tvalid(m_tvalid[2]), .m_axis_2_tready(m_tready[2]), .m_axis_2_tlast(m_tlast[2]),
        .m_axis_3_tdata(m_tdata[3]), .m_axis_3_tkeep(m_tkeep[3]), .m_axis_3_tuser(m_tuser[3]),
        .m_axis_3_tvalid(m_tvalid[3]), .m_axis_3_tready(m_tready[3]), .m_axis_3_tlast(m_tlast[3]),
        .m_axis_4_tdata(m_tdata[4]), .m_axis_4_tkeep(m_tkeep[4]), .m_axis_4_tuser(m_tuser[4]),
        .m_axis_4_tvalid(m_tvalid[4]), .m_axis_4_tready(m_tready[4]), .m_axis_4_tlast(m_tlast[4]),
        .pkt_fwd(pkt_fwd), .pkt_drop(pkt_drop), .drop_count(drop_count)
    );

    assign vld = {m_tvalid[4], m_tvalid[3], m_tvalid[2], m_tvalid[1], m_tvalid[0]};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Random beat with bytes 12..15 forced to the given header values
    function automatic logic [255:0] hdr(input logic [7:0] b12, input logic [7:0] b13,
                                         input logic [7:0] b14, input logic [7:0] b15);
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
        d[103:96]  = b12;
        d[111:104] = b13;
        d[119:112] = b14;
        d[127:120] = b15;
        return d;
    endfunction

    task automatic drive(input logic [255:0] d, input logic last);
        s_tdata  = d;
        s_tkeep  = $urandom;
        for (int i = 0; i < 9; i++) s_tuser[i*32 +: 32] = $urandom;
        s_tuser[303:288] = 16'($urandom);
        s_tlast  = last;
        s_tvalid = 1'b1;
    endtask

    // Whole packet with all readies high; later beats look like VID 1 headers
    task automatic send(input string tag, input logic [255:0] first, input int n,
                        input logic [4:0] exp_vld, input logic exp_fwd);
        for (int i = 0; i < n; i++) begin
            drive((i == 0) ? first : hdr(8'h81, 8'h00, 8'h00, 8'h01), i == n - 1);
            #1;
            chk({tag, "_vld"}, 320'(vld), 320'(exp_vld));
            chk({tag, "_rdy"}, 320'(s_tready), 320'(1'b1));
            tick();
            chk({tag, "_fwd"}, 320'(pkt_fwd), 320'(exp_fwd && i == 0));
            chk({tag, "_drop"}, 320'(pkt_drop), 320'(!exp_fwd && i == 0));
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    logic       pat [10] = '{1, 0, 0, 1, 1, 0, 1, 0, 1, 1};
    logic [255:0] beats [5];

    initial begin
        int b;
        rstn = 1'b0;
        for (int k = 0; k < 5; k++) m_tready[k] = 1'b1;
        drive(hdr(8'h81, 8'h00, 8'h00, 8'h03), 1'b0);
        tick(); tick();
        chk("rst_vld", 320'(vld), 320'(0));
        chk("rst_rdy", 320'(s_tready), 320'(0));
        chk("rst_fwd", 320'(pkt_fwd), 320'(0));
        chk("rst_cnt", 320'(drop_count), 320'(0));
        s_tvalid = 1'b0;
        rstn = 1'b1;
        tick();
        chk("idle_rdy", 320'(s_tready), 320'(0));
        chk("idle_vld", 320'(vld), 320'(0));

        // VID 3 -> port 2, then untagged drop
        send("vid3", hdr(8'h81, 8'h00, 8'h00, 8'h03), 4, 5'b00100, 1'b1);
        chk("vid3_cnt", 320'(drop_count), 320'(0));
        send("untag", hdr(8'h08, 8'h00, 8'h00, 8'h03), 3, 5'b00000, 1'b0);
        chk("untag_cnt", 320'(drop_count), 320'(1));

        // VID range edges, bad TPID low byte, PCP bits ignored
        send("vid0", hdr(8'h81, 8'h00, 8'h00, 8'h00), 1, 5'b00000, 1'b0);
        send("vid6", hdr(8'h81, 8'h00, 8'h00, 8'h06), 2, 5'b00000, 1'b0);
        chk("edge_cnt", 320'(drop_count), 320'(3));
        send("vid5", hdr(8'h81, 8'h00, 8'h00, 8'h05), 2, 5'b10000, 1'b1);
        send("tpid", hdr(8'h81, 8'h01, 8'h00, 8'h02), 1, 5'b00000, 1'b0);
        send("pcp", hdr(8'h81, 8'h00, 8'hF0, 8'h02), 1, 5'b00010, 1'b1);
        send("vid257", hdr(8'h81, 8'h00, 8'h01, 8'h01), 1, 5'b00000, 1'b0);
        chk("edge_cnt2", 320'(drop_count), 320'(5));

        // VID 1 with port 0 backpressure
        beats[0] = hdr(8'h81, 8'h00, 8'h00, 8'h01);
        for (int i = 1; i < 5; i++) beats[i] = hdr(8'h81, 8'h00, 8'h00, 8'h04);
        b = 0;
        for (int c = 0; c < 10 && b < 5; c++) begin
            drive(beats[b], b == 4);
            m_tready[0] = pat[c];
            #1;
            chk("bp_vld", 320'(vld), 320'(5'b00001));
            chk("bp_rdy", 320'(s_tready), 320'(pat[c]));
            chk("bp_data", 320'(m_tdata[0]), 320'(beats[b]));
            chk("bp_last", 320'(m_tlast[0]), 320'(b == 4));
            tick();
            if (pat[c]) b++;
        end
        chk("bp_count", 320'(b), 320'(5));
        s_tvalid = 1'b0;
        m_tready[0] = 1'b1;
        tick();

        // Back-to-back single-beat packets, with sideband pass-through
        drive(hdr(8'h81, 8'h00, 8'h00, 8'h02), 1'b1);
        #1;
        chk("b2b0_vld", 320'(vld), 320'(5'b00010));
        chk("b2b0_user", 320'(m_tuser[1]), 320'(s_tuser));
        chk("b2b0_keep", 320'(m_tkeep[3]), 320'(s_tkeep));
        tick();
        chk("b2b0_fwd", 320'(pkt_fwd), 320'(1));
        drive(hdr(8'h81, 8'h00, 8'h00, 8'h04), 1'b1);
        #1;
        chk("b2b1_vld", 320'(vld), 320'(5'b01000));
        tick();
        chk("b2b1_fwd", 320'(pkt_fwd), 320'(1));
        drive(hdr(8'h81, 8'h00, 8'h00, 8'h01), 1'b1);
        #1;
        chk("b2b2_vld", 320'(vld), 320'(5'b00001));
        tick();
        chk("b2b2_fwd", 320'(pkt_fwd), 320'(1));
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        tick();
        chk("b2b_end", 320'(pkt_fwd), 320'(0));

        // Reset on beat 2 of a 6-beat VID 2 packet
        drive(hdr(8'h81, 8'h00, 8'h00, 8'h02), 1'b0);
        #1;
        chk("rm0_vld", 320'(vld), 320'(5'b00010));
        tick();
        drive(hdr(8'h81, 8'h00, 8'h00, 8'h03), 1'b0);
        tick();
        drive(hdr(8'h81, 8'h00, 8'h00, 8'h03), 1'b0);
        rstn = 1'b0;
        #1;
        chk("rm2_vld", 320'(vld), 320'(0));
        chk("rm2_rdy", 320'(s_tready), 320'(0));
        tick();
        chk("rm_cnt", 320'(drop_count), 320'(0));
        rstn = 1'b1;
        drive(hdr(8'h00, 8'h00, 8'h00, 8'h02), 1'b0);
        #1;
        chk("rm3_vld", 320'(vld), 320'(0));
        chk("rm3_rdy", 320'(s_tready), 320'(1));
        tick();
        chk("rm3_drop", 320'(pkt_drop), 320'(1));
        chk("rm3_cnt", 320'(drop_count), 320'(1));
        for (int i = 4; i < 6; i++) begin
            drive(hdr(8'h81, 8'h00, 8'h00, 8'h02), i == 5);
            #1;
            chk("rm_tail_vld", 320'(vld), 320'(0));
            tick();
        end
        chk("rm_tail_cnt", 320'(drop_count), 320'(1));
        send("after", hdr(8'h81, 8'h00, 8'h00, 8'h04), 1, 5'b01000, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
